vector_alu_sequencer: RTL and testbench
=======================================

# vector_alu_sequencer

Command-driven controller that sequences one `vector_element_alu` instance against the vector register file. It accepts ALU commands from the host-interface side over a valid/ready handshake and drives register-file read addresses. It configures the ALU (`op_sel`, `scalar_sel`, `scalar`), pulses `set`, waits for the ALU result-valid `en`, and writes the result back to the destination register. Commands execute strictly one at a time, in order.

## Interface
Parameters:
- `BITS`, 8, element/scalar width; matches the ALU.
- `NREGS`, 8, number of vector registers; `RA = $clog2(NREGS)`.
- `TIMEOUT`, 15, maximum WAIT cycles for `alu_en` before abort; minimum 1.
- `FIFO_DEPTH`, 4, command FIFO depth; power of two; used only with `VSEQ_CMD_FIFO_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted on `cmd_valid && cmd_ready` at the rising edge.
- `cmd_op` in 3: ALU opcode.
- `cmd_scalar_sel` in 1: 1 selects scalar for the B operand.
- `cmd_scalar` in BITS: scalar operand.
- `cmd_src_a` in RA: source register for operand A.
- `cmd_src_b` in RA: source register for operand B.
- `cmd_dst` in RA: destination register.
- `rf_rd_addr_a` out RA: register-file read address for A.
- `rf_rd_addr_b` out RA: register-file read address for B.
- `rf_we` out 1: write-back strobe.
- `rf_wr_addr` out RA: write-back address.
- `alu_op_sel` out 3: ALU operation select.
- `alu_scalar_sel` out 1: ALU scalar select.
- `alu_scalar` out BITS: ALU scalar operand.
- `alu_set` out 1: one-cycle capture pulse to the ALU result register.
- `alu_en` in 1: ALU result valid.
- `busy` out 1: high whenever state ≠ IDLE or the FIFO is non-empty.
- `done` out 1: one-cycle pulse, coincident with `rf_we`.
- `err` out 1: one-cycle pulse on timeout.
- `err_sticky` out 1: set by `err`; cleared only by reset.

## Operation
- Opcodes: ADD=000, SUB=001, MUL=010, CMP=011, AND=100, OR=101, XOR=110, NOT=111. The opcode is passed through unmodified to `alu_op_sel`.
- FSM states and transitions:
  - IDLE: when a command is available, latch it into the current-command register and go to READ.
  - READ: drive `rf_rd_addr_a/b` from the latched command. The register file has 1-cycle read latency. Go to EXEC.
  - EXEC: `alu_set`=1 for exactly this cycle. Go to WAIT and clear the timeout counter.
  - WAIT: if `alu_en`=1, go to WRITE. Otherwise increment the counter. When the counter reaches TIMEOUT, pulse `err`, set `err_sticky`, and return to IDLE with no write-back.
  - WRITE: `rf_we`=1, `rf_wr_addr`=`cmd_dst`, `done`=1. Go to IDLE.
- `alu_op_sel`, `alu_scalar_sel`, `alu_scalar` and `rf_rd_addr_*` hold the latched command from READ through WRITE. In IDLE they hold their last values.
- `cmd_dst` equal to `cmd_src_a` or `cmd_src_b` is legal. Reads complete before write-back.
- Reset (any state, mid-operation included): FSM goes to IDLE and the FIFO is flushed. All outputs are 0, except that `cmd_ready` is also 0 while `rst` is high. No partial write is issued.

## Timing
- Command accepted at edge T. READ at T+1, EXEC at T+2, WAIT from T+3. With `alu_en` high at T+3, WRITE (`rf_we`, `done`) occurs at T+4 and the FSM is in IDLE at T+5.
- Minimum command-to-done latency is 4 cycles. Peak throughput is 1 command per 5 cycles.
- The timeout abort occurs in the cycle after the TIMEOUT-th WAIT cycle without `alu_en`.
- A command accepted while in WRITE is started at the next IDLE.

## Configuration
- `VSEQ_CMD_FIFO_EN` defined:
  - Commands enter a FIFO_DEPTH-entry FIFO.
  - `cmd_ready` = !full, independent of FSM state.
  - IDLE pops the FIFO head when it is non-empty.
  - A simultaneous push and pop is legal when full; the head is consumed.
- `VSEQ_CMD_FIFO_EN` undefined:
  - No FIFO.
  - `cmd_ready` = (state == IDLE) && !rst.
  - IDLE latches directly from the `cmd_*` ports.

## Structure
- `vector_alu_pkg` holds:
  - the opcode enum `alu_op_e`,
  - the FSM enum `vseq_state_e`,
  - the packed struct `vseq_cmd_t` {op, scalar_sel, scalar, src_a, src_b, dst}.
- One sub-module, `vseq_cmd_fifo`: synchronous FIFO of `vseq_cmd_t` with full/empty flags and wrap-around pointers. It is instantiated only under `VSEQ_CMD_FIFO_EN`.

## Test plan
- Reset release, then ADD src_a=1, src_b=2, dst=3 with `alu_en` returned one cycle after `alu_set`:
  - `rf_rd_addr_a`=1 and `rf_rd_addr_b`=2 at T+1;
  - `alu_set` at T+2;
  - `rf_we`, `rf_wr_addr`=3 and `done` at T+4.
- SUB with `cmd_scalar_sel`=1 and `cmd_scalar`=8'h05: `alu_op_sel`=001, `alu_scalar_sel`=1 and `alu_scalar`=05 are held from T+1 through T+4.
- With FIFO enabled, back-to-back push of 5 commands:
  - `cmd_ready` drops after 4 entries while the first is executing;
  - all 5 `done` pulses occur in order, spaced 5 cycles apart;
  - `busy` stays high throughout.
- `alu_en` held at 0:
  - `err` pulses exactly after TIMEOUT=15 WAIT cycles;
  - no `rf_we`;
  - `err_sticky`=1;
  - the next command executes normally.
- `rst` asserted during WAIT: all outputs go to 0 asynchronously, no `done` or `rf_we`, and the FIFO is empty after release.
- Without FIFO: a command offered during EXEC is held with `cmd_ready`=0 until IDLE, then accepted.

Source files
------------

// File: rtl/vector_alu_sequencer_pkg.sv
// vector_alu_pkg: shared types for the vector ALU sequencer.
//   alu_op_e     - ALU opcode, passed unmodified to the ALU op select
//   vseq_state_e - sequencer FSM state (also exposed on dbg_state)
//   vseq_cmd_t   - one queued/latched ALU command
// The struct field widths come from VSEQ_BITS / VSEQ_RA. The sequencer's
// BITS / NREGS parameters must match them.
package vector_alu_pkg;

  localparam int VSEQ_BITS  = 8;
  localparam int VSEQ_NREGS = 8;
  localparam int VSEQ_RA    = $clog2(VSEQ_NREGS);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MUL = 3'b010,
    ALU_CMP = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_NOT = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4
  } vseq_state_e;

  typedef struct packed {
    alu_op_e              op;
    logic                 scalar_sel;
    logic [VSEQ_BITS-1:0] scalar;
    logic [VSEQ_RA-1:0]   src_a;
    logic [VSEQ_RA-1:0]   src_b;
    logic [VSEQ_RA-1:0]   dst;
  } vseq_cmd_t;

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// vector_alu_sequencer_if: command channel from the host-interface side.
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high. The master holds cmd_valid and all cmd_* fields
// stable until that edge; cmd_ready may change independently of cmd_valid.
//   master: host side (drives cmd_valid, cmd_*; receives cmd_ready)
//   slave : sequencer side
interface vector_alu_sequencer_if #(
  parameter int BITS = 8,
  parameter int RA   = 3
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic            cmd_scalar_sel;
  logic [BITS-1:0] cmd_scalar;
  logic [RA-1:0]   cmd_src_a;
  logic [RA-1:0]   cmd_src_b;
  logic [RA-1:0]   cmd_dst;

  modport master (
    output cmd_valid, cmd_op, cmd_scalar_sel, cmd_scalar,
           cmd_src_a, cmd_src_b, cmd_dst,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_scalar_sel, cmd_scalar,
           cmd_src_a, cmd_src_b, cmd_dst,
    output cmd_ready
  );
endinterface

// File: rtl/vseq_cmd_fifo.sv
// vseq_cmd_fifo: synchronous FIFO of vseq_cmd_t.
//   clk, rst    - clock, asynchronous active-high reset (flushes pointers)
//   push, din   - write request and data; accepted when not full, or when
//                 full and a pop happens in the same cycle
//   pop, dout   - read request; dout shows the head combinationally
//   full, empty - status flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vseq_cmd_fifo
  import vector_alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  vseq_cmd_t din,
  input  logic      pop,
  output vseq_cmd_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  vseq_cmd_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer: runs ALU commands one at a time against the vector
// register file: READ (rf address), EXEC (alu_set pulse), WAIT (for alu_en,
// bounded by TIMEOUT), WRITE (rf_we + done).
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   cmd                 - command channel (vector_alu_sequencer_if.slave)
//   rf_rd_addr_a/b      - register-file read addresses (held from READ on)
//   rf_we, rf_wr_addr   - write-back strobe and address
//   alu_op_sel, alu_scalar_sel, alu_scalar - ALU configuration
//   alu_set             - one-cycle capture pulse to the ALU
//   alu_en              - ALU result valid
//   busy, done, err, err_sticky - status
//   dbg_state           - current FSM state
// Optional feature: define VSEQ_CMD_FIFO_EN to buffer commands in a
// FIFO_DEPTH-entry FIFO; otherwise commands are taken only in IDLE.
module vector_alu_sequencer
  import vector_alu_pkg::*;
#(
  parameter int BITS       = VSEQ_BITS,
  parameter int NREGS      = VSEQ_NREGS,
  parameter int TIMEOUT    = 15,
  parameter int FIFO_DEPTH = 4,
  localparam int RA        = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  vector_alu_sequencer_if.slave  cmd,
  output logic [RA-1:0]          rf_rd_addr_a,
  output logic [RA-1:0]          rf_rd_addr_b,
  output logic                   rf_we,
  output logic [RA-1:0]          rf_wr_addr,
  output logic [2:0]             alu_op_sel,
  output logic                   alu_scalar_sel,
  output logic [BITS-1:0]        alu_scalar,
  output logic                   alu_set,
  input  logic                   alu_en,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   err_sticky,
  output vseq_state_e            dbg_state
);
  localparam int CW = $clog2(TIMEOUT + 1);

  vseq_state_e state;
  vseq_cmd_t   cur;
  vseq_cmd_t   in_cmd;
  vseq_cmd_t   head;
  logic        head_valid;
  logic [CW-1:0] wait_cnt;

  always_comb begin
    in_cmd            = '0;
    in_cmd.op         = alu_op_e'(cmd.cmd_op);
    in_cmd.scalar_sel = cmd.cmd_scalar_sel;
    in_cmd.scalar     = cmd.cmd_scalar;
    in_cmd.src_a      = cmd.cmd_src_a;
    in_cmd.src_b      = cmd.cmd_src_b;
    in_cmd.dst        = cmd.cmd_dst;
  end

`ifdef VSEQ_CMD_FIFO_EN
  logic fifo_full;
  logic fifo_empty;
  logic fifo_pop;

  assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;
  assign head_valid = !fifo_empty;
  assign cmd.cmd_ready = !fifo_full && !rst;
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  vseq_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd.cmd_valid && cmd.cmd_ready),
    .din   (in_cmd),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  assign head       = in_cmd;
  assign head_valid = cmd.cmd_valid;
  assign cmd.cmd_ready = (state == ST_IDLE) && !rst;
  assign busy       = (state != ST_IDLE);
`endif

  // The latched command drives the ALU and read addresses directly, so they
  // hold from READ through WRITE and keep their last value in IDLE.
  assign rf_rd_addr_a   = cur.src_a;
  assign rf_rd_addr_b   = cur.src_b;
  assign rf_wr_addr     = cur.dst;
  assign alu_op_sel     = cur.op;
  assign alu_scalar_sel = cur.scalar_sel;
  assign alu_scalar     = cur.scalar;
  assign dbg_state      = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur        <= '0;
      wait_cnt   <= '0;
      alu_set    <= 1'b0;
      rf_we      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      alu_set <= 1'b0;
      rf_we   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (head_valid) begin
            cur   <= head;
            state <= ST_READ;
          end
        end
        ST_READ: begin
          // Read data arrives one cycle later, in time for the capture.
          alu_set <= 1'b1;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_en) begin
            rf_we <= 1'b1;
            done  <= 1'b1;
            state <= ST_WRITE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th WAIT cycle without a result.
            err        <= 1'b1;
            err_sticky <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WRITE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_alu_sequencer.sv
module tb_vector_alu_sequencer;
  import vector_alu_pkg::*;

`ifdef VSEQ_CMD_FIFO_EN
  localparam int FIFO_LAT = 1;
`else
  localparam int FIFO_LAT = 0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, alu_op_sel;
  logic       rf_we, alu_scalar_sel, alu_set, alu_en;
  logic [7:0] alu_scalar;
  logic       busy, done, err, err_sticky;
  vseq_state_e dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  bit auto_en = 1;
  logic [2:0] exp_q[$];

  vector_alu_sequencer_if #(.BITS(8), .RA(3)) cmd_if ();

  vector_alu_sequencer dut (
    .clk(clk), .rst(rst), .cmd(cmd_if),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr),
    .alu_op_sel(alu_op_sel), .alu_scalar_sel(alu_scalar_sel),
    .alu_scalar(alu_scalar), .alu_set(alu_set), .alu_en(alu_en),
    .busy(busy), .done(done), .err(err), .err_sticky(err_sticky),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 0;
  always #5 clk = ~clk;

  // ALU responder: result valid in the cycle after alu_set when enabled.
  initial alu_en = 0;
  always begin
    bit s;
    @(posedge clk);
    s = alu_set;
    #1;
    alu_en = auto_en && s && !rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: offer one command, return one cycle after the accepting edge
  task automatic send_cmd(input logic [2:0] op, input logic ssel,
                          input logic [7:0] sc, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] d);
    bit acc = 0;
    cmd_if.cmd_valid      = 1;
    cmd_if.cmd_op         = op;
    cmd_if.cmd_scalar_sel = ssel;
    cmd_if.cmd_scalar     = sc;
    cmd_if.cmd_src_a      = a;
    cmd_if.cmd_src_b      = b;
    cmd_if.cmd_dst        = d;
    for (int i = 0; i < 64 && !acc; i++) begin
      if (cmd_if.cmd_ready === 1'b1) acc = 1;
      tick();
    end
    cmd_if.cmd_valid = 0;
    n_total++;
    if (!acc) $display("FAIL accept: got no handshake, required one within 64 cycles");
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1;
    cmd_if.cmd_valid = 0;
    cmd_if.cmd_op = 0; cmd_if.cmd_scalar_sel = 0; cmd_if.cmd_scalar = 0;
    cmd_if.cmd_src_a = 0; cmd_if.cmd_src_b = 0; cmd_if.cmd_dst = 0;
    repeat (3) tick();
    n_total++;
    if ({cmd_if.cmd_ready, busy, rf_we, done, err, err_sticky, alu_set} !== 7'b0)
      $display("FAIL reset_ctl: got %b required 0000000",
               {cmd_if.cmd_ready, busy, rf_we, done, err, err_sticky, alu_set});
    else n_pass++;
    n_total++;
    if ({rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, alu_op_sel, alu_scalar_sel, alu_scalar} !== 21'b0)
      $display("FAIL reset_data: got %h required 0",
               {rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr, alu_op_sel, alu_scalar_sel, alu_scalar});
    else n_pass++;
    rst = 0;
    tick();
    n_total++;
    if (cmd_if.cmd_ready !== 1'b1 || dbg_state !== ST_IDLE)
      $display("FAIL reset_release: got ready=%b state=%0d required ready=1 state=0",
               cmd_if.cmd_ready, dbg_state);
    else n_pass++;
  endtask

  task automatic test_add();
    send_cmd(3'b000, 0, 8'h00, 3'd1, 3'd2, 3'd3);
    repeat (FIFO_LAT) tick();
    // T+1
    n_total++;
    if (dbg_state !== ST_READ || rf_rd_addr_a !== 3'd1 || rf_rd_addr_b !== 3'd2)
      $display("FAIL add_read: got state=%0d a=%0d b=%0d required 1/1/2",
               dbg_state, rf_rd_addr_a, rf_rd_addr_b);
    else n_pass++;
    tick(); // T+2
    n_total++;
    if (alu_set !== 1'b1 || rf_we !== 1'b0)
      $display("FAIL add_set: got set=%b we=%b required 1/0", alu_set, rf_we);
    else n_pass++;
    tick(); // T+3
    n_total++;
    if (alu_set !== 1'b0 || dbg_state !== ST_WAIT)
      $display("FAIL add_wait: got set=%b state=%0d required 0/3", alu_set, dbg_state);
    else n_pass++;
    tick(); // T+4
    n_total++;
    if (rf_we !== 1'b1 || done !== 1'b1 || rf_wr_addr !== 3'd3)
      $display("FAIL add_write: got we=%b done=%b wa=%0d required 1/1/3",
               rf_we, done, rf_wr_addr);
    else n_pass++;
    tick(); // T+5
    n_total++;
    if (rf_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE)
      $display("FAIL add_idle: got we=%b done=%b busy=%b state=%0d required 0/0/0/0",
               rf_we, done, busy, dbg_state);
    else n_pass++;
  endtask

  task automatic test_scalar();
    send_cmd(3'b001, 1, 8'h05, 3'd4, 3'd5, 3'd6);
    repeat (FIFO_LAT) tick();
    for (int k = 1; k <= 4; k++) begin
      n_total++;
      if (alu_op_sel !== 3'b001 || alu_scalar_sel !== 1'b1 || alu_scalar !== 8'h05)
        $display("FAIL scalar_hold_t%0d: got op=%b ss=%b sc=%h required 001/1/05",
                 k, alu_op_sel, alu_scalar_sel, alu_scalar);
      else n_pass++;
      if (k == 4) begin
        n_total++;
        if (done !== 1'b1 || rf_wr_addr !== 3'd6)
          $display("FAIL scalar_done: got done=%b wa=%0d required 1/6", done, rf_wr_addr);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] dsts [5];
    int n_done = 0;
    dsts[0] = 3'd1; dsts[1] = 3'd3; dsts[2] = 3'd5; dsts[3] = 3'd7; dsts[4] = 3'd2;
    for (int i = 0; i < 5; i++) exp_q.push_back(dsts[i]);
    fork
      begin
        for (int i = 0; i < 5; i++)
          send_cmd(3'(i + 2), 0, 8'(i * 17), 3'(i), 3'(i + 1), dsts[i]);
`ifdef VSEQ_CMD_FIFO_EN
        n_total++;
        if (cmd_if.cmd_ready !== 1'b0)
          $display("FAIL b2b_full: got ready=%b required 0", cmd_if.cmd_ready);
        else n_pass++;
`endif
      end
      begin
        int last = 0;
        int busy_low = 0;
        for (int cyc = 0; cyc < 60 && n_done < 5; cyc++) begin
          if (cyc > 0 && busy !== 1'b1) busy_low++;
          if (done === 1'b1) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            n_total++;
            if (rf_wr_addr !== e)
              $display("FAIL b2b_order%0d: got wa=%0d required %0d", n_done, rf_wr_addr, e);
            else n_pass++;
            if (n_done > 0) begin
              n_total++;
              if (cyc - last !== 5)
                $display("FAIL b2b_spacing%0d: got %0d cycles required 5", n_done, cyc - last);
              else n_pass++;
            end
            last = cyc;
            n_done++;
          end
          tick();
        end
        n_total++;
        if (n_done !== 5) $display("FAIL b2b_count: got %0d dones required 5", n_done);
        else n_pass++;
`ifdef VSEQ_CMD_FIFO_EN
        n_total++;
        if (busy_low !== 0) $display("FAIL b2b_busy: got %0d low cycles required 0", busy_low);
        else n_pass++;
`endif
      end
    join
    exp_q.delete();
    repeat (2) tick();
  endtask

`ifndef VSEQ_CMD_FIFO_EN
  task automatic test_hold();
    send_cmd(3'b100, 0, 8'h00, 3'd2, 3'd3, 3'd4);
    tick(); // EXEC: offer the next command
    cmd_if.cmd_valid = 1;
    cmd_if.cmd_op = 3'b101; cmd_if.cmd_scalar_sel = 0; cmd_if.cmd_scalar = 8'h00;
    cmd_if.cmd_src_a = 3'd6; cmd_if.cmd_src_b = 3'd7; cmd_if.cmd_dst = 3'd0;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (cmd_if.cmd_ready !== 1'b0)
        $display("FAIL hold_ready%0d: got %b required 0", k, cmd_if.cmd_ready);
      else n_pass++;
      tick();
    end
    // back in IDLE; first command must not have been disturbed
    n_total++;
    if (cmd_if.cmd_ready !== 1'b1 || rf_rd_addr_a !== 3'd2)
      $display("FAIL hold_idle: got ready=%b a=%0d required 1/2", cmd_if.cmd_ready, rf_rd_addr_a);
    else n_pass++;
    tick();
    cmd_if.cmd_valid = 0;
    n_total++;
    if (dbg_state !== ST_READ || rf_rd_addr_a !== 3'd6 || alu_op_sel !== 3'b101)
      $display("FAIL hold_accept: got state=%0d a=%0d op=%b required 1/6/101",
               dbg_state, rf_rd_addr_a, alu_op_sel);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (done !== 1'b1 || rf_wr_addr !== 3'd0)
      $display("FAIL hold_done: got done=%b wa=%0d required 1/0", done, rf_wr_addr);
    else n_pass++;
    tick();
  endtask
`endif

  task automatic test_timeout();
    int bad = 0;
    auto_en = 0;
    send_cmd(3'b010, 0, 8'h00, 3'd0, 3'd1, 3'd7);
    repeat (FIFO_LAT + 2) tick(); // first WAIT cycle
    for (int k = 0; k < 15; k++) begin
      if (dbg_state !== ST_WAIT || err !== 1'b0 || rf_we !== 1'b0) bad++;
      tick();
    end
    n_total++;
    if (bad !== 0) $display("FAIL to_wait: got %0d bad WAIT cycles required 0", bad);
    else n_pass++;
    n_total++;
    if (err !== 1'b1 || err_sticky !== 1'b1 || rf_we !== 1'b0 || dbg_state !== ST_IDLE)
      $display("FAIL to_abort: got err=%b sticky=%b we=%b state=%0d required 1/1/0/0",
               err, err_sticky, rf_we, dbg_state);
    else n_pass++;
    tick();
    n_total++;
    if (err !== 1'b0 || err_sticky !== 1'b1 || done !== 1'b0)
      $display("FAIL to_after: got err=%b sticky=%b done=%b required 0/1/0", err, err_sticky, done);
    else n_pass++;
    auto_en = 1;
    send_cmd(3'b110, 0, 8'h00, 3'd3, 3'd4, 3'd5);
    repeat (FIFO_LAT + 3) tick();
    n_total++;
    if (done !== 1'b1 || rf_wr_addr !== 3'd5)
      $display("FAIL to_next: got done=%b wa=%0d required 1/5", done, rf_wr_addr);
    else n_pass++;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    auto_en = 0;
    send_cmd(3'b110, 1, 8'hff, 3'd5, 3'd6, 3'd2);
    repeat (FIFO_LAT) tick();
`ifdef VSEQ_CMD_FIFO_EN
    send_cmd(3'b000, 0, 8'h11, 3'd1, 3'd1, 3'd1);
    send_cmd(3'b001, 0, 8'h22, 3'd2, 3'd2, 3'd3);
`else
    repeat (2) tick();
`endif
    n_total++;
    if (dbg_state !== ST_WAIT)
      $display("FAIL rm_pre: got state=%0d required 3", dbg_state);
    else n_pass++;
    #2 rst = 1;
    #1;
    n_total++;
    if ({cmd_if.cmd_ready, busy, rf_we, done, err, err_sticky, alu_set} !== 7'b0 ||
        dbg_state !== ST_IDLE)
      $display("FAIL rm_ctl: got %b state=%0d required 0000000 state=0",
               {cmd_if.cmd_ready, busy, rf_we, done, err, err_sticky, alu_set}, dbg_state);
    else n_pass++;
    n_total++;
    if ({rf_rd_addr_a, rf_rd_addr_b, alu_op_sel, alu_scalar_sel, alu_scalar} !== 18'b0)
      $display("FAIL rm_data: got %h required 0",
               {rf_rd_addr_a, rf_rd_addr_b, alu_op_sel, alu_scalar_sel, alu_scalar});
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (rf_we !== 1'b0 || done !== 1'b0) seen++;
    end
    rst = 0;
    auto_en = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rf_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL rm_quiet: got %0d active cycles required 0", seen);
    else n_pass++;
    n_total++;
    if (cmd_if.cmd_ready !== 1'b1 || dbg_state !== ST_IDLE)
      $display("FAIL rm_release: got ready=%b state=%0d required 1/0", cmd_if.cmd_ready, dbg_state);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_scalar();
    test_back_to_back();
`ifndef VSEQ_CMD_FIFO_EN
    test_hold();
`endif
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
